coriolis_ker1_subker1_obuf: RTL and testbench

Elastic output buffer placed directly downstream of the coriolis sub-kernel-1 divide-by-constant stage. It accepts the divider's FloPoCo-format stream (2-bit exception field + IEEE single) and holds it in a DEPTH-entry first-word-fall-through FIFO. The divider's `iready` follows `oready` combinationally; this buffer registers its own `iready`, breaking that path and absorbing back-pressure from the next kernel. It also maintains sticky infinity/NaN flags and an output element counter for host-side status.

---
 rtl/coriolis_ker1_subker1_obuf.sv | 108 ++++++++++
 tb/tb_coriolis_ker1_subker1_obuf.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/coriolis_ker1_subker1_obuf.sv
// Elastic FWFT output buffer behind the coriolis sub-kernel-1 divider.
// Registers iready to cut the combinational ready path, and keeps sticky inf/NaN flags and a delivered-word count.
module coriolis_ker1_subker1_obuf #(
  parameter int STREAMW = 34,
  parameter int DEPTH   = 4,
  parameter int CNTW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ivalid_in1_s0,
  input  logic [STREAMW-1:0]         in1_s0,
  output logic                       iready,
  output logic                       ovalid,
  output logic [STREAMW-1:0]         out1_s0,
  input  logic                       oready,
  input  logic                       clr_flags,
  output logic                       exc_inf,
  output logic                       exc_nan,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNTW-1:0]            nout
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);
  localparam logic [1:0] EXC_INF = 2'b10;
  localparam logic [1:0] EXC_NAN = 2'b11;

  logic [AW-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [OW-1:0]      occ_reg, occ_next;
  logic               iready_reg, iready_next;
  logic               inf_reg, inf_next;
  logic               nan_reg, nan_next;
  logic [CNTW-1:0]    nout_reg, nout_next;

  logic               wr;
  logic               rd;
  logic [1:0]         exc_field;
  logic [DEPTH-1:0]   wr_sel;
  logic [STREAMW-1:0] mem [DEPTH];

  assign exc_field = in1_s0[STREAMW-1 -: 2];
  assign wr        = ivalid_in1_s0 & iready_reg;
  assign rd        = (occ_reg != '0) & oready;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    occ_next    = occ_reg;
    nout_next   = nout_reg;
    if (wr) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (rd) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
      nout_next   = nout_reg + CNTW'(1);
    end
    case ({wr, rd})
      2'b10:   occ_next = occ_reg + OW'(1);
      2'b01:   occ_next = occ_reg - OW'(1);
      default: occ_next = occ_reg;
    endcase
    // Ready looks at next-cycle occupancy so it is a pure register output.
    iready_next = (occ_next != FULL_OCC);
    // A flag-setting write beats a same-cycle clear.
    inf_next = (inf_reg & ~clr_flags) | (wr & (exc_field == EXC_INF));
    nan_next = (nan_reg & ~clr_flags) | (wr & (exc_field == EXC_NAN));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
      iready_reg <= 1'b0;
      inf_reg    <= 1'b0;
      nan_reg    <= 1'b0;
      nout_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      occ_reg    <= occ_next;
      iready_reg <= iready_next;
      inf_reg    <= inf_next;
      nan_reg    <= nan_next;
      nout_reg   <= nout_next;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
    assign wr_sel[gi] = wr & (wr_ptr_reg == AW'(gi));
  end

  // Storage has no reset; stale entries are hidden by the empty mask below.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_sel[i]) mem[i] <= in1_s0;
    end
  end

  assign iready    = iready_reg;
  assign ovalid    = (occ_reg != '0);
  assign out1_s0   = ovalid ? mem[rd_ptr_reg] : '0;
  assign exc_inf   = inf_reg;
  assign exc_nan   = nan_reg;
  assign occupancy = occ_reg;
  assign nout      = nout_reg;

endmodule

// File: tb/tb_coriolis_ker1_subker1_obuf.sv
// Directed table plus scoreboarded sequences for coriolis_ker1_subker1_obuf (DEPTH=4).
module tb_coriolis_ker1_subker1_obuf;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ivalid = 1'b0;
  logic [33:0] din = '0;
  logic        iready;
  logic        ovalid;
  logic [33:0] out1;
  logic        oready = 1'b0;
  logic        clr = 1'b0;
  logic        exc_inf;
  logic        exc_nan;
  logic [2:0]  occupancy;
  logic [31:0] nout;

  int errors = 0;
  int checks = 0;

  coriolis_ker1_subker1_obuf #(.STREAMW(34), .DEPTH(4), .CNTW(32)) dut (
    .clk(clk), .rst(rst), .ivalid_in1_s0(ivalid), .in1_s0(din), .iready(iready),
    .ovalid(ovalid), .out1_s0(out1), .oready(oready), .clr_flags(clr),
    .exc_inf(exc_inf), .exc_nan(exc_nan), .occupancy(occupancy), .nout(nout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [33:0] d;
    logic        ordy;
    logic        clr;
    logic        e_ov;
    logic [33:0] e_out;
    logic        e_ir;
    logic [2:0]  e_occ;
    logic        e_inf;
    logic        e_nan;
    logic [31:0] e_nout;
  } vec_t;

  vec_t tbl[18];

  // Reference model state for the scoreboarded sequences
  logic [33:0] m_q[$];
  logic        m_ir = 1'b0;
  logic [31:0] m_nout = '0;
  int          delivered = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("ovalid", 64'(ovalid), 64'(m_q.size() != 0));
    chk("out1_s0", 64'(out1), (m_q.size() != 0) ? 64'(m_q[0]) : 64'd0);
    chk("iready", 64'(iready), 64'(m_ir));
    chk("occupancy", 64'(occupancy), 64'(m_q.size()));
    chk("nout", 64'(nout), 64'(m_nout));
  endtask

  task automatic cycle(input logic iv, input logic [33:0] d, input logic ordy, output logic acc);
    logic wr, rd;
    ivalid = iv; din = d; oready = ordy; clr = 1'b0;
    wr = iv & m_ir;
    rd = (m_q.size() != 0) & ordy;
    @(posedge clk);
    if (rd) begin
      void'(m_q.pop_front());
      delivered++;
      m_nout++;
    end
    if (wr) m_q.push_back(d);
    m_ir = (m_q.size() != 4);
    acc = wr;
    #1;
    chk_model();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ovalid"}, 64'(ovalid), 64'd0);
    chk({tag, "_out1"}, 64'(out1), 64'd0);
    chk({tag, "_iready"}, 64'(iready), 64'd0);
    chk({tag, "_occ"}, 64'(occupancy), 64'd0);
    chk({tag, "_inf"}, 64'(exc_inf), 64'd0);
    chk({tag, "_nan"}, 64'(exc_nan), 64'd0);
    chk({tag, "_nout"}, 64'(nout), 64'd0);
  endtask

  localparam logic [33:0] A = 34'h1_3F800000;
  localparam logic [33:0] B = 34'h1_40000000;
  localparam logic [33:0] D = 34'h2_7F800000;
  localparam logic [33:0] E = 34'h3_7FC00000;
  localparam logic [33:0] F = 34'h3_00000001;
  localparam logic [33:0] G = 34'h0_00000000;
  localparam logic [33:0] H = 34'h1_12345678;
  localparam logic [33:0] I = 34'h1_0BADBEEF;

  initial begin
    logic        acc;
    int          seq;
    int          cyc;
    logic [33:0] rdata;

    //            iv  data ordy clr | ov  out ir occ inf nan nout
    tbl[0]  = '{1'b0, G, 1'b1, 1'b0, 1'b0, G, 1'b1, 3'd0, 1'b0, 1'b0, 32'd0};
    tbl[1]  = '{1'b1, A, 1'b1, 1'b0, 1'b1, A, 1'b1, 3'd1, 1'b0, 1'b0, 32'd0};
    tbl[2]  = '{1'b1, B, 1'b1, 1'b0, 1'b1, B, 1'b1, 3'd1, 1'b0, 1'b0, 32'd1};
    tbl[3]  = '{1'b0, G, 1'b1, 1'b0, 1'b0, G, 1'b1, 3'd0, 1'b0, 1'b0, 32'd2};
    tbl[4]  = '{1'b1, D, 1'b0, 1'b0, 1'b1, D, 1'b1, 3'd1, 1'b1, 1'b0, 32'd2};
    tbl[5]  = '{1'b1, E, 1'b0, 1'b0, 1'b1, D, 1'b1, 3'd2, 1'b1, 1'b1, 32'd2};
    tbl[6]  = '{1'b0, G, 1'b0, 1'b1, 1'b1, D, 1'b1, 3'd2, 1'b0, 1'b0, 32'd2};
    tbl[7]  = '{1'b1, F, 1'b0, 1'b1, 1'b1, D, 1'b1, 3'd3, 1'b0, 1'b1, 32'd2};
    tbl[8]  = '{1'b0, G, 1'b1, 1'b1, 1'b1, E, 1'b1, 3'd2, 1'b0, 1'b0, 32'd3};
    tbl[9]  = '{1'b1, G, 1'b0, 1'b0, 1'b1, E, 1'b1, 3'd3, 1'b0, 1'b0, 32'd3};
    tbl[10] = '{1'b1, H, 1'b0, 1'b0, 1'b1, E, 1'b0, 3'd4, 1'b0, 1'b0, 32'd3};
    tbl[11] = '{1'b1, I, 1'b0, 1'b0, 1'b1, E, 1'b0, 3'd4, 1'b0, 1'b0, 32'd3};
    tbl[12] = '{1'b1, I, 1'b1, 1'b0, 1'b1, F, 1'b1, 3'd3, 1'b0, 1'b0, 32'd4};
    tbl[13] = '{1'b1, I, 1'b1, 1'b0, 1'b1, G, 1'b1, 3'd3, 1'b0, 1'b0, 32'd5};
    tbl[14] = '{1'b0, G, 1'b1, 1'b0, 1'b1, H, 1'b1, 3'd2, 1'b0, 1'b0, 32'd6};
    tbl[15] = '{1'b0, G, 1'b1, 1'b0, 1'b1, I, 1'b1, 3'd1, 1'b0, 1'b0, 32'd7};
    tbl[16] = '{1'b0, G, 1'b1, 1'b0, 1'b0, G, 1'b1, 3'd0, 1'b0, 1'b0, 32'd8};
    tbl[17] = '{1'b0, G, 1'b1, 1'b0, 1'b0, G, 1'b1, 3'd0, 1'b0, 1'b0, 32'd8};

    // Reset state, then release between edges
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < 18; v++) begin
      ivalid = tbl[v].iv; din = tbl[v].d; oready = tbl[v].ordy; clr = tbl[v].clr;
      @(posedge clk);
      #1;
      $display("vec %0d: iv=%0b d=%09h ordy=%0b clr=%0b -> ov=%0b out=%09h ir=%0b occ=%0d inf=%0b nan=%0b nout=%0d",
               v, tbl[v].iv, tbl[v].d, tbl[v].ordy, tbl[v].clr, ovalid, out1, iready, occupancy,
               exc_inf, exc_nan, nout);
      chk($sformatf("v%0d_ovalid", v), 64'(ovalid), 64'(tbl[v].e_ov));
      chk($sformatf("v%0d_out1", v), 64'(out1), 64'(tbl[v].e_out));
      chk($sformatf("v%0d_iready", v), 64'(iready), 64'(tbl[v].e_ir));
      chk($sformatf("v%0d_occ", v), 64'(occupancy), 64'(tbl[v].e_occ));
      chk($sformatf("v%0d_inf", v), 64'(exc_inf), 64'(tbl[v].e_inf));
      chk($sformatf("v%0d_nan", v), 64'(exc_nan), 64'(tbl[v].e_nan));
      chk($sformatf("v%0d_nout", v), 64'(nout), 64'(tbl[v].e_nout));
    end
    clr = 1'b0;

    // Hand the known post-table state to the model: empty, 8 delivered
    m_ir = 1'b1;
    m_nout = 32'd8;
    seq = 1;

    // Fill to full, then stream with both sides always active
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, {2'b01, 32'(seq)}, 1'b0, acc);
      if (acc) seq++;
    end
    delivered = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, {2'b01, 32'(seq)}, 1'b1, acc);
      if (acc) seq++;
      chk("stream_nogap", 64'(ovalid), 64'd1);
      chk("stream_occ_range", 64'((occupancy >= 3'd3) && (occupancy <= 3'd4)), 64'd1);
    end
    chk("stream_delivered", 64'(delivered), 64'd20);
    cyc = 0;
    while (m_q.size() != 0 && cyc < 10) begin
      cycle(1'b0, '0, 1'b1, acc);
      cyc++;
    end
    chk("stream_drained", 64'(occupancy), 64'd0);

    // Random traffic, 500 words, then asynchronous reset mid-stream
    delivered = 0;
    cyc = 0;
    while (delivered < 500 && cyc < 4000) begin
      rdata = {(seq % 16 == 7) ? 2'b10 : 2'b01, 32'(seq)};
      cycle(1'($urandom_range(0, 1)), rdata, 1'($urandom_range(0, 1)), acc);
      if (acc) seq++;
      cyc++;
    end
    chk("rand1_delivered", 64'(delivered >= 500), 64'd1);
    // Make sure there is something in flight when reset hits
    cycle(1'b1, {2'b01, 32'(seq)}, 1'b0, acc);
    if (acc) seq++;

    #2 rst = 1'b0;
    ivalid = 1'b0;
    oready = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    chk_reset_outputs("rst_hold");
    m_q.delete();
    m_ir = 1'b0;
    m_nout = '0;
    @(negedge clk);
    rst = 1'b1;

    delivered = 0;
    cyc = 0;
    while (delivered < 500 && cyc < 4000) begin
      rdata = {2'b01, 32'(seq)};
      cycle(1'($urandom_range(0, 1)), rdata, 1'($urandom_range(0, 1)), acc);
      if (acc) seq++;
      cyc++;
    end
    chk("rand2_delivered", 64'(delivered >= 500), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
